spi_ram_loader: RTL and testbench
=================================

Name: spi_ram_loader

Overview:
SPI slave front-end that lets an external host load and read back the Baby's 32-word store while the Baby is halted. It sits directly upstream of the RAM multiplexer. It converts serial SPI transactions into word-wide RAM accesses, driving the multiplexer's SPI clock, address, data and chip-select inputs. It samples the read path from the multiplexer's SPI data output. The whole block runs on the system clock; external SPI pins are synchronised internally.

Parameters:
ADDR_W, 5, RAM word address width
DATA_W, 32, RAM word width
SYNC_STAGES, 2, flop stages on each external SPI input

Ports:
clk_i  input  1  system clock; must be at least 8x the SPI SCLK frequency
rst_ni  input  1  asynchronous active-low reset
sclk_i  input  1  external SPI clock, mode 0 (CPOL=0, CPHA=0)
cs_ni  input  1  external SPI chip select, active low
mosi_i  input  1  external serial data in
miso_o  output  1  external serial data out
baby_halt_i  input  1  Baby halted; RAM access is permitted only while high
spi_cs_o  output  1  to multiplexer spi_cs
ram_clk_o  output  1  to multiplexer spi_clk_i; one-cycle access strobe
ram_addr_o  output  ADDR_W  to multiplexer spi_addr_i
ram_data_o  output  DATA_W  to multiplexer spi_data_i; write data
ram_data_i  input  DATA_W  from multiplexer spi_data_o; read data
busy_o  output  1  transaction in progress
err_o  output  1  access attempted while not halted

Behaviour:
- Reset: all outputs are 0 and state is IDLE. The synchronised cs_n resets to 1.
- Input conditioning:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - SCLK rise and fall are detected from the synchronised value.
  - mosi is sampled on each detected rise.
- spi_cs_o = NOT(synchronised cs_n).
- busy_o = (state != IDLE).
- Frame format: an 8-bit command, MSB first, followed by one or more 32-bit data words, MSB first.
  - cmd[7]: 1 = write, 0 = read.
  - cmd[6:5]: ignored.
  - cmd[4:0]: start address.
- IDLE -> CMD on synchronised cs_n falling. At this point: bit counter = 0 and err_o cleared.
- CMD: shift in 8 bits. When the 8th rise is seen:
  - if baby_halt_i = 0: set err_o = 1 and go to DISCARD;
  - otherwise load the address into ram_addr_o;
  - then write -> WDATA, read -> RD_PULSE.
- WDATA:
  - Shift in 32 bits.
  - On the 32nd rise: ram_data_o <= assembled word and go to WR_PULSE.
  - ram_data_o and ram_addr_o are held stable from the cycle before ram_clk_o rises until after it falls.
- WR_PULSE:
  - ram_clk_o = 1 for exactly one cycle.
  - Next cycle: ram_addr_o increments (31 wraps to 0), bit counter = 0, go to WDATA.
- RD_PULSE: ram_clk_o = 1 for one cycle at the current address, then go to RD_CAP.
- RD_CAP:
  - Capture ram_data_i into the tx shift register.
  - ram_addr_o increments with wrap.
  - Go to RDATA with bit counter = 0.
- RDATA:
  - miso_o = tx[31] continuously.
  - Each SCLK rise increments the bit counter.
  - Each SCLK fall shifts tx left, but only when bit counter != 0.
  - This guarantees the MSB is held valid through the first data rise.
  - On the 32nd rise, go to RD_PULSE to fetch the next word (burst).
- DISCARD: ignore all SCLK activity; miso_o = 0 and ram_clk_o = 0.
- baby_halt_i falling in any active state except IDLE: set err_o, go to DISCARD.
  - A ram_clk_o pulse already high completes normally.
- cs_n deassert (synchronised) in any state: go to IDLE next cycle.
  - A partial write word is discarded and no strobe is issued.
  - If the deassert lands in WR_PULSE or RD_PULSE, that single-cycle pulse completes first.
  - miso_o returns to 0 in IDLE.
- err_o is sticky until the next cs_n falling or reset.
- Reset mid-transaction: immediate return to reset values, with no further strobes.
- Only address/data values are registered; no arithmetic beyond the 5-bit increment, which wraps modulo 32.

Test Plan:
- Halted, send 0x81 then 0xDEADBEEF -> exactly one ram_clk_o pulse with ram_addr_o = 1 and ram_data_o = 0xDEADBEEF stable around the pulse; err_o = 0.
- Halted, send 0x9F then 0x00000011, 0x00000022 -> pulses at address 31 with 0x11, then address 0 with 0x22 (wrap).
- Halted, RAM model holds 0x12345678 at 5 and 0xCAFEF00D at 6; send 0x05 and clock 64 bits -> miso returns 0x12345678 then 0xCAFEF00D MSB first, with one ram_clk_o pulse per word.
- baby_halt_i = 0, send 0x81 plus data -> err_o = 1, no ram_clk_o pulses, miso_o = 0. The next cs_n falling clears err_o.
- Halted write, cs_n deasserted after 20 data bits -> no ram_clk_o pulse, busy_o = 0 within SYNC_STAGES+1 cycles.
- rst_ni pulsed low mid-read -> all outputs 0 immediately. A subsequent clean write to address 2 succeeds.

Source files
------------

// File: rtl/spi_ram_loader_if.sv
// Word-wide port between the SPI loader and the Baby's RAM multiplexer.
// master = loader side, slave = multiplexer side.
interface spi_ram_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              spi_cs_o;
    logic              ram_clk_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_data_o;
    logic [DATA_W-1:0] ram_data_i;

    modport master (
        output spi_cs_o, ram_clk_o, ram_addr_o, ram_data_o,
        input  ram_data_i
    );

    modport slave (
        input  spi_cs_o, ram_clk_o, ram_addr_o, ram_data_o,
        output ram_data_i
    );
endinterface

// File: rtl/spi_ram_loader.sv
// SPI mode-0 slave that turns command/data frames into word-wide RAM strobes
// for loading and reading back the Baby's store while it is halted.
module spi_ram_loader #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sclk_i,
    input  logic cs_ni,
    input  logic mosi_i,
    output logic miso_o,
    input  logic baby_halt_i,
    output logic busy_o,
    output logic err_o,
    spi_ram_loader_if.master ram
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CMD      = 3'd1;
    localparam logic [2:0] S_WDATA    = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_RD_PULSE = 3'd4;
    localparam logic [2:0] S_RD_CAP   = 3'd5;
    localparam logic [2:0] S_RDATA    = 3'd6;
    localparam logic [2:0] S_DISCARD  = 3'd7;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sclk_prev_q, sclk_prev_d;
    logic cs_prev_q, cs_prev_d;
    logic halt_prev_q, halt_prev_d;
    logic [2:0] state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic strobe_q, strobe_d;
    logic err_q, err_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, halt_fall;
    logic [DATA_W-1:0] rx_next;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign halt_fall = halt_prev_q & ~baby_halt_i;
    assign rx_next   = {rx_q[DATA_W-2:0], mosi_s};

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_ni};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        halt_prev_d = baby_halt_i;
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        err_d       = err_q;
        // The strobe trails its pulse state by one cycle so address and data
        // have already settled for a full cycle when it rises.
        strobe_d    = (state_q == S_WR_PULSE) || (state_q == S_RD_PULSE);
        if (strobe_q) addr_d = addr_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_CMD: begin
                if (sclk_rise) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CMD_LAST) begin
                        cnt_d = '0;
                        if (!baby_halt_i) begin
                            err_d   = 1'b1;
                            state_d = S_DISCARD;
                        end else begin
                            addr_d  = rx_next[ADDR_W-1:0];
                            state_d = rx_next[7] ? S_WDATA : S_RD_PULSE;
                        end
                    end
                end
            end
            S_WDATA: begin
                if (sclk_rise) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == WORD_LAST) begin
                        data_d  = rx_next;
                        state_d = S_WR_PULSE;
                    end
                end
            end
            S_WR_PULSE: begin
                cnt_d   = '0;
                state_d = S_WDATA;
            end
            S_RD_PULSE: state_d = S_RD_CAP;
            S_RD_CAP: begin
                tx_d    = ram.ram_data_i;
                cnt_d   = '0;
                state_d = S_RDATA;
            end
            S_RDATA: begin
                if (sclk_rise) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == WORD_LAST) state_d = S_RD_PULSE;
                end
                // No shift before the first rise keeps the MSB on miso for it.
                if (sclk_fall && cnt_q != '0) tx_d = {tx_q[DATA_W-2:0], 1'b0};
            end
            default: ;
        endcase

        if (halt_fall && state_q != S_IDLE && state_q != S_DISCARD) begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
        end
        if (cs_s && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            halt_prev_q <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            halt_prev_q <= halt_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            err_q       <= err_d;
        end
    end

    assign miso_o         = (state_q == S_RDATA) & tx_q[DATA_W-1];
    assign busy_o         = (state_q != S_IDLE);
    assign err_o          = err_q;
    assign ram.spi_cs_o   = ~cs_s;
    assign ram.ram_clk_o  = strobe_q;
    assign ram.ram_addr_o = addr_q;
    assign ram.ram_data_o = data_q;
endmodule

// File: tb/tb_spi_ram_loader.sv
// Bench for spi_ram_loader: table of directed frames, corner-case sequences
// and random frames checked against a frame-level reference model.
module tb_spi_ram_loader;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic halt = 1'b1;
    logic miso, busy, err;
    logic [31:0] mem [32];

    spi_ram_loader_if ram_if ();
    assign ram_if.ram_data_i = mem[ram_if.ram_addr_o];

    spi_ram_loader dut (
        .clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk), .cs_ni(cs_n), .mosi_i(mosi),
        .miso_o(miso), .baby_halt_i(halt), .busy_o(busy), .err_o(err), .ram(ram_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        int          nw;
        bit          halt;
        logic [31:0] w0, w1;
        int          exp_n;
        logic [4:0]  exp_a0;
        bit          exp_err;
    } vec_t;

    int n_vec = 0, n_err = 0;
    int stab_bad = 0, width_bad = 0;
    logic [36:0] strobes [$];
    logic prev_clk, after;
    logic [4:0] prev_addr;
    logic [31:0] prev_data, last_data;
    logic [31:0] wbuf [4], rbuf [4], exp_rd [4];
    bit miso_any;
    logic err_end;
    int sidx, stab0, wid0;

    // Strobe monitor: logs every ram_clk cycle and checks width and data stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_clk <= 1'b0;
            after    <= 1'b0;
        end else begin
            if (after && ram_if.ram_data_o !== last_data) stab_bad <= stab_bad + 1;
            after <= ram_if.ram_clk_o;
            if (ram_if.ram_clk_o) begin
                if (prev_clk) width_bad <= width_bad + 1;
                if (ram_if.ram_addr_o !== prev_addr || ram_if.ram_data_o !== prev_data)
                    stab_bad <= stab_bad + 1;
                strobes.push_back({ram_if.ram_addr_o, ram_if.ram_data_o});
                last_data <= ram_if.ram_data_o;
            end
            prev_clk  <= ram_if.ram_clk_o;
            prev_addr <= ram_if.ram_addr_o;
            prev_data <= ram_if.ram_data_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            tick(HALF);
            rx = {rx[30:0], miso};
            miso_any = miso_any | miso;
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int nw, input bit h);
        logic [31:0] dummy;
        halt = h;
        tick(2);
        sidx = strobes.size();
        stab0 = stab_bad;
        wid0 = width_bad;
        miso_any = 1'b0;
        cs_n = 1'b0;
        tick(HALF);
        chk("err_clear", err, 0);
        chk("busy_start", busy, 1);
        chk("spi_cs", ram_if.spi_cs_o, 1);
        spi_bits({24'h0, cmd}, 8, dummy);
        for (int k = 0; k < nw; k++) spi_bits(wbuf[k], 32, rbuf[k]);
        tick(HALF);
        err_end = err;
        cs_n = 1'b1;
        tick(8);
        chk("busy_end", busy, 0);
        halt = 1'b1;
    endtask

    // Reference model: writes strobe once per full word, reads strobe once per
    // word plus a prefetch; nothing strobes when not halted.
    function automatic int model_strobes(input logic [7:0] cmd, input int nw, input bit h);
        if (!h) return 0;
        return cmd[7] ? nw : nw + 1;
    endfunction

    task automatic check_frame(input logic [7:0] cmd, input int nw, input bit h,
                               input int exp_n, input logic [4:0] a0, input bit exp_err);
        int got;
        got = strobes.size() - sidx;
        chk("strobe_count", got, exp_n);
        for (int k = 0; k < exp_n && k < got; k++) begin
            chk("strobe_addr", strobes[sidx+k][36:32], 5'(a0 + 5'(k)));
            if (cmd[7]) chk("strobe_data", strobes[sidx+k][31:0], wbuf[k]);
        end
        if (h && !cmd[7])
            for (int k = 0; k < nw; k++) chk("miso_word", rbuf[k], exp_rd[k]);
        if (!h) chk("miso_quiet", miso_any, 0);
        chk("err_end", err_end, exp_err);
        chk("strobe_stable", stab_bad - stab0, 0);
        chk("strobe_width", width_bad - wid0, 0);
    endtask

    vec_t vt [6];
    int base;
    logic [31:0] tmp;

    initial begin
        vt[0] = '{8'h81, 1, 1'b1, 32'hDEADBEEF, 32'h0,        1, 5'd1,  1'b0};
        vt[1] = '{8'h9F, 2, 1'b1, 32'h00000011, 32'h00000022, 2, 5'd31, 1'b0};
        vt[2] = '{8'h05, 2, 1'b1, 32'h12345678, 32'hCAFEF00D, 3, 5'd5,  1'b0};
        vt[3] = '{8'h81, 1, 1'b0, 32'hA5A5A5A5, 32'h0,        0, 5'd0,  1'b1};
        vt[4] = '{8'hE3, 1, 1'b1, 32'h0F0F1234, 32'h0,        1, 5'd3,  1'b0};
        vt[5] = '{8'h7F, 1, 1'b1, 32'h80000001, 32'h5555AAAA, 2, 5'd31, 1'b0};
        for (int j = 0; j < 32; j++) mem[j] = $urandom;

        tick(3);
        chk("rst_miso", miso, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_spi_cs", ram_if.spi_cs_o, 0);
        chk("rst_ram_clk", ram_if.ram_clk_o, 0);
        chk("rst_addr", ram_if.ram_addr_o, 0);
        chk("rst_data", ram_if.ram_data_o, 0);
        rst_n = 1'b1;
        tick(4);

        for (int i = 0; i < 6; i++) begin
            wbuf[0] = vt[i].w0;
            wbuf[1] = vt[i].w1;
            if (!vt[i].cmd[7]) begin
                mem[vt[i].cmd[4:0]] = vt[i].w0;
                mem[5'(vt[i].cmd[4:0] + 5'd1)] = vt[i].w1;
                exp_rd[0] = vt[i].w0;
                exp_rd[1] = vt[i].w1;
            end
            run_frame(vt[i].cmd, vt[i].nw, vt[i].halt);
            check_frame(vt[i].cmd, vt[i].nw, vt[i].halt, vt[i].exp_n, vt[i].exp_a0, vt[i].exp_err);
        end

        // Partial write word abandoned by cs_n rising.
        base = strobes.size();
        cs_n = 1'b0;
        tick(HALF);
        spi_bits(32'h81, 8, tmp);
        spi_bits(32'h000ABCDE, 20, tmp);
        cs_n = 1'b1;
        tick(2);
        chk("abort_busy_hold", busy, 1);
        tick(1);
        chk("abort_busy_drop", busy, 0);
        tick(40);
        chk("abort_no_strobe", strobes.size() - base, 0);

        // Halt drops in the middle of a write word.
        base = strobes.size();
        miso_any = 1'b0;
        cs_n = 1'b0;
        tick(HALF);
        spi_bits(32'h84, 8, tmp);
        spi_bits(32'h3C3C3C3C, 10, tmp);
        halt = 1'b0;
        tick(4);
        chk("halt_fall_err", err, 1);
        chk("halt_fall_busy", busy, 1);
        spi_bits(32'h3C3C3C3C, 22, tmp);
        chk("halt_fall_no_strobe", strobes.size() - base, 0);
        chk("halt_fall_miso", miso_any, 0);
        cs_n = 1'b1;
        tick(8);
        chk("err_sticky", err, 1);
        chk("halt_fall_idle", busy, 0);
        halt = 1'b1;

        // Reset pulsed during a read burst, then a clean write to address 2.
        mem[5] = 32'hFFFF0000;
        cs_n = 1'b0;
        tick(HALF);
        spi_bits(32'h05, 8, tmp);
        spi_bits(32'h0, 12, tmp);
        tick(2);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_addr", ram_if.ram_addr_o, 6);
        rst_n = 1'b0;
        #1;
        chk("midrst_miso", miso, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_spi_cs", ram_if.spi_cs_o, 0);
        chk("midrst_ram_clk", ram_if.ram_clk_o, 0);
        chk("midrst_addr", ram_if.ram_addr_o, 0);
        chk("midrst_data", ram_if.ram_data_o, 0);
        cs_n = 1'b1;
        sclk = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(4);
        wbuf[0] = $urandom;
        run_frame(8'h82, 1, 1'b1);
        check_frame(8'h82, 1, 1'b1, 1, 5'd2, 1'b0);

        // Random frames against the model.
        for (int r = 0; r < 10; r++) begin
            logic [7:0] cmd;
            int nw;
            bit h;
            cmd = 8'($urandom);
            nw = $urandom_range(1, 3);
            h = ($urandom_range(0, 4) != 0);
            for (int j = 0; j < 32; j++) mem[j] = $urandom;
            for (int k = 0; k < 4; k++) begin
                wbuf[k] = $urandom;
                exp_rd[k] = mem[5'(cmd[4:0] + 5'(k))];
            end
            run_frame(cmd, nw, h);
            check_frame(cmd, nw, h, model_strobes(cmd, nw, h), cmd[4:0], !h);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
